rv32i_dbus_wb: RTL and testbench

Data-bus bridge between the rv32i core's MEM-stage memory port and a Wishbone classic master interface. It adds a posted store buffer of configurable depth and generates the `stall_pipl` back-pressure the core consumes. Load results are sign- or zero-extended per `mem_op_mem`. Byte selects and lane alignment are generated here.

---
 rtl/rv32i_dbus_wb.sv | 206 ++++++++++++++++++++
 tb/tb_rv32i_dbus_wb.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_dbus_wb.sv
// rv32i MEM-stage data port to Wishbone classic bridge with posted store buffer.
// Optional bus watchdog: define DBUS_TIMEOUT_EN.
module rv32i_dbus_wb #(
  parameter int SB_DEPTH       = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] mem_addr_mem,
  input  logic [31:0] mem_wdata_mem,
  input  logic        mem_write_mem,
  input  logic        mem_read_mem,
  input  logic [2:0]  mem_op_mem,
  output logic [31:0] mem_rdata_mem,
  output logic        stall_pipl,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic        sb_empty_o,
  output logic        misaligned_o,
  output logic        bus_err_o
);

  localparam int AW = $clog2(SB_DEPTH);
  localparam logic [AW:0] ONE = 1;

  typedef enum logic [1:0] {
    IDLE, ST_BUS, LD_BUS, LD_DONE
  } state_t;

  state_t state;

  logic [29:0] fifo_adr [SB_DEPTH];
  logic [31:0] fifo_dat [SB_DEPTH];
  logic [3:0]  fifo_sel [SB_DEPTH];
  logic [AW:0] wptr, rptr, wptr_n, rptr_n;

  logic        is_b, is_h, is_w, mis;
  logic        ld_req, st_req, push, pop;
  logic        empty, full, done, tmo;
  logic [31:0] ln_dat;
  logic [3:0]  ln_sel;
  logic [31:0] ld_word, ld_sh, ld_ext;
  logic [1:0]  ld_off;
  logic [2:0]  ld_op;

  assign is_b = mem_op_mem[1:0] == 2'b00;
  assign is_h = mem_op_mem[1:0] == 2'b01;
  assign is_w = mem_op_mem[1:0] == 2'b10;
  assign mis  = (is_h & mem_addr_mem[0])
              | (is_w & (|mem_addr_mem[1:0]));

  assign ld_req = mem_read_mem & ~mis;
  assign st_req = mem_write_mem & ~mis;

  assign empty = wptr == rptr;
  assign full  = (wptr[AW] != rptr[AW])
              && (wptr[AW-1:0] == rptr[AW-1:0]);

  assign done = wb_ack_i | wb_err_i | tmo;
  assign pop  = (state == ST_BUS) & done;

  // a pop in this cycle frees a slot, so a full buffer still takes the push
  assign stall_pipl = (ld_req & (state != LD_DONE))
                    | (st_req & full & ~pop);
  assign push = st_req & ~stall_pipl;

  assign wptr_n = push ? wptr + ONE : wptr;
  assign rptr_n = pop ? rptr + ONE : rptr;

  always_comb begin
    ln_dat = mem_wdata_mem;
    ln_sel = 4'b1111;
    unique case (1'b1)
      is_b: begin
        ln_dat = {24'b0, mem_wdata_mem[7:0]}
                 << {mem_addr_mem[1:0], 3'b000};
        ln_sel = 4'b0001 << mem_addr_mem[1:0];
      end
      is_h: begin
        ln_dat = {16'b0, mem_wdata_mem[15:0]}
                 << {mem_addr_mem[1], 4'b0000};
        ln_sel = mem_addr_mem[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  assign ld_sh = ld_word >> {ld_off, 3'b000};

  always_comb begin
    ld_ext = ld_word;
    unique case (ld_op)
      3'b000:  ld_ext = {{24{ld_sh[7]}}, ld_sh[7:0]};
      3'b001:  ld_ext = {{16{ld_sh[15]}}, ld_sh[15:0]};
      3'b100:  ld_ext = {24'b0, ld_sh[7:0]};
      3'b101:  ld_ext = {16'b0, ld_sh[15:0]};
      default: ld_ext = ld_word;
    endcase
  end

  // a misaligned load completes in its own cycle with zero data
  assign mem_rdata_mem = (mem_read_mem & mis) ? 32'b0 : ld_ext;

`ifdef DBUS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TONE = 1;
  logic [TW-1:0] tcnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      tcnt <= '0;
    else if (!wb_cyc_o) tcnt <= '0;
    else               tcnt <= tcnt + TONE;
  end

  assign tmo = wb_cyc_o & (tcnt == TLIM);
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_adr[wptr[AW-1:0]] <= mem_addr_mem[31:2];
      fifo_dat[wptr[AW-1:0]] <= ln_dat;
      fifo_sel[wptr[AW-1:0]] <= ln_sel;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      wptr         <= '0;
      rptr         <= '0;
      wb_cyc_o     <= 1'b0;
      wb_stb_o     <= 1'b0;
      wb_we_o      <= 1'b0;
      wb_adr_o     <= '0;
      wb_dat_o     <= '0;
      wb_sel_o     <= '0;
      ld_word      <= '0;
      ld_off       <= '0;
      ld_op        <= '0;
      sb_empty_o   <= 1'b1;
      misaligned_o <= 1'b0;
      bus_err_o    <= 1'b0;
    end else begin
      wptr         <= wptr_n;
      rptr         <= rptr_n;
      sb_empty_o   <= wptr_n == rptr_n;
      misaligned_o <= (mem_read_mem | mem_write_mem) & mis;
      bus_err_o    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (ld_req && empty) begin
            state    <= LD_BUS;
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_we_o  <= 1'b0;
            wb_adr_o <= {mem_addr_mem[31:2], 2'b00};
            wb_sel_o <= ln_sel;
            ld_off   <= mem_addr_mem[1:0];
            ld_op    <= mem_op_mem;
          end else if (!empty || push) begin
            // an empty buffer issues the incoming store straight away
            state    <= ST_BUS;
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_we_o  <= 1'b1;
            wb_adr_o <= empty ? {mem_addr_mem[31:2], 2'b00}
                              : {fifo_adr[rptr[AW-1:0]], 2'b00};
            wb_dat_o <= empty ? ln_dat : fifo_dat[rptr[AW-1:0]];
            wb_sel_o <= empty ? ln_sel : fifo_sel[rptr[AW-1:0]];
          end
        end
        ST_BUS: begin
          if (done) begin
            state     <= IDLE;
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            wb_we_o   <= 1'b0;
            bus_err_o <= ~wb_ack_i;
          end
        end
        LD_BUS: begin
          if (done) begin
            state     <= LD_DONE;
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            ld_word   <= wb_ack_i ? wb_dat_i : 32'b0;
            bus_err_o <= ~wb_ack_i;
          end
        end
        LD_DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_dbus_wb.sv
// Scoreboard bench for rv32i_dbus_wb: directed loads/stores against a Wishbone slave model.
module tb_rv32i_dbus_wb;

  localparam int SBD = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] mem_addr_mem = '0;
  logic [31:0] mem_wdata_mem = '0;
  logic        mem_write_mem = 1'b0;
  logic        mem_read_mem = 1'b0;
  logic [2:0]  mem_op_mem = '0;
  logic [31:0] mem_rdata_mem;
  logic        stall_pipl;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i = '0;
  logic        wb_ack_i = 1'b0;
  logic        wb_err_i = 1'b0;
  logic        sb_empty_o, misaligned_o, bus_err_o;

  rv32i_dbus_wb #(.SB_DEPTH(SBD), .TIMEOUT_CYCLES(255)) dut (
    .clk(clk), .reset_n(reset_n),
    .mem_addr_mem(mem_addr_mem), .mem_wdata_mem(mem_wdata_mem),
    .mem_write_mem(mem_write_mem), .mem_read_mem(mem_read_mem),
    .mem_op_mem(mem_op_mem), .mem_rdata_mem(mem_rdata_mem),
    .stall_pipl(stall_pipl),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .sb_empty_o(sb_empty_o), .misaligned_o(misaligned_o),
    .bus_err_o(bus_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } bus_t;

  bus_t        bus_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] mem [logic [29:0]];

  int checks = 0;
  int errors = 0;
  int wait_st = 0;
  bit err_mode = 0;
  bit no_ack = 0;
  int cnt = 0;
  int mis_cnt = 0;
  int berr_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // slave model and bus-side scoreboard
  always @(negedge clk) begin
    bus_t        e;
    logic [31:0] w;
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    wb_dat_i = '0;
    if (wb_cyc_o && wb_stb_o) begin
      if (cnt == wait_st && !no_ack) begin
        cnt = 0;
        if (err_mode) wb_err_i = 1'b1;
        else          wb_ack_i = 1'b1;
        w = mem.exists(wb_adr_o[31:2]) ? mem[wb_adr_o[31:2]] : 32'b0;
        if (!wb_we_o) begin
          wb_dat_i = w;
        end else if (!err_mode) begin
          for (int b = 0; b < 4; b++)
            if (wb_sel_o[b]) w[8*b+:8] = wb_dat_o[8*b+:8];
          mem[wb_adr_o[31:2]] = w;
        end
        if (bus_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL bus_unexpected got=%h want=none", wb_adr_o);
        end else begin
          e = bus_q.pop_front();
          chk("bus_we", {31'b0, wb_we_o}, {31'b0, e.we});
          chk("bus_adr", wb_adr_o, e.adr);
          chk("bus_sel", {28'b0, wb_sel_o}, {28'b0, e.sel});
          if (e.we) chk("bus_dat", wb_dat_o, e.dat);
        end
      end else begin
        cnt++;
      end
    end else begin
      cnt = 0;
    end
  end

  // core-side monitor
  always @(negedge clk) begin
    #2;
    if (reset_n) begin
      if (misaligned_o) mis_cnt++;
      if (bus_err_o) berr_cnt++;
      if (mem_read_mem && !stall_pipl) begin
        if (rd_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ld_unexpected got=%h want=none", mem_rdata_mem);
        end else begin
          chk("ld_data", mem_rdata_mem, rd_q.pop_front());
        end
      end
    end
  end

  task automatic req(input bit rd, input bit wr, input logic [31:0] a,
                     input logic [31:0] wd, input logic [2:0] op,
                     output int stalls);
    mem_read_mem  = rd;
    mem_write_mem = wr;
    mem_addr_mem  = a;
    mem_wdata_mem = wd;
    mem_op_mem    = op;
    stalls = 0;
    #2;
    while (stall_pipl && stalls < 400) begin
      stalls++;
      @(negedge clk);
      #2;
    end
    if (stall_pipl) begin
      checks++;
      errors++;
      $display("FAIL req_timeout got=stalled want=accept adr=%h", a);
    end
    @(negedge clk);
    mem_read_mem  = 1'b0;
    mem_write_mem = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] op, input logic [31:0] edat,
                       input logic [3:0] esel, output int st);
    bus_q.push_back('{1'b1, {a[31:2], 2'b00}, edat, esel});
    req(1'b0, 1'b1, a, d, op, st);
  endtask

  task automatic load(input logic [31:0] a, input logic [2:0] op,
                      input logic [3:0] esel, input logic [31:0] exp,
                      output int st);
    bus_q.push_back('{1'b0, {a[31:2], 2'b00}, 32'b0, esel});
    rd_q.push_back(exp);
    req(1'b1, 1'b0, a, 32'b0, op, st);
  endtask

  task automatic wait_empty(input string name);
    int n = 0;
    while (!(sb_empty_o && !wb_cyc_o) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(name, {31'b0, sb_empty_o}, 32'd1);
  endtask

  int st;
  int s5 [5];

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_cyc", {31'b0, wb_cyc_o}, 0);
    chk("rst_stb", {31'b0, wb_stb_o}, 0);
    chk("rst_we", {31'b0, wb_we_o}, 0);
    chk("rst_adr", wb_adr_o, 0);
    chk("rst_dat", wb_dat_o, 0);
    chk("rst_sel", {28'b0, wb_sel_o}, 0);
    chk("rst_rdata", mem_rdata_mem, 0);
    chk("rst_sb_empty", {31'b0, sb_empty_o}, 1);
    chk("rst_stall", {31'b0, stall_pipl}, 0);
    chk("rst_mis", {31'b0, misaligned_o}, 0);
    chk("rst_berr", {31'b0, bus_err_o}, 0);
    reset_n = 1'b1;
    @(negedge clk);

    store(32'h100, 32'hDEADBEEF, 3'b010, 32'hDEADBEEF, 4'b1111, st);
    chk("sw_stall", st, 0);
    wait_empty("sw_sb_empty");

    store(32'h103, 32'h80, 3'b000, 32'h80000000, 4'b1000, st);
    load(32'h103, 3'b000, 4'b1000, 32'hFFFFFF80, st);
    load(32'h103, 3'b100, 4'b1000, 32'h00000080, st);
    chk("lbu_stall", st, 2);
    load(32'h102, 3'b001, 4'b1100, 32'hFFFF80AD, st);
    load(32'h100, 3'b101, 4'b0011, 32'h0000BEEF, st);
    load(32'h101, 3'b000, 4'b0010, 32'hFFFFFFBE, st);
    load(32'h100, 3'b010, 4'b1111, 32'h80ADBEEF, st);

    rd_q.push_back(32'h0);
    req(1'b1, 1'b0, 32'h102, 32'h0, 3'b010, st);
    chk("lw_mis_stall", st, 0);
    req(1'b0, 1'b1, 32'h101, 32'h1234, 3'b001, st);
    chk("sh_mis_stall", st, 0);

    store(32'h200, 32'h11111111, 3'b010, 32'h11111111, 4'b1111, st);
    store(32'h200, 32'h22222222, 3'b010, 32'h22222222, 4'b1111, st);
    store(32'h200, 32'h33333333, 3'b010, 32'h33333333, 4'b1111, st);
    load(32'h200, 3'b010, 4'b1111, 32'h33333333, st);

    wait_st = 5;
    for (int i = 0; i < 5; i++)
      store(32'h300 + 32'(4 * i), 32'hA0 + 32'(i), 3'b010,
            32'hA0 + 32'(i), 4'b1111, s5[i]);
    for (int i = 0; i < 4; i++) chk("fill_stall", s5[i], 0);
    checks++;
    if (s5[4] == 0) begin
      errors++;
      $display("FAIL full_stall got=%0d want=>0", s5[4]);
    end
    wait_empty("fill_sb_empty");
    load(32'h304, 3'b010, 4'b1111, 32'h000000A1, st);
    chk("lw_wait5_stall", st, 7);
    wait_st = 0;

    err_mode = 1;
    load(32'h100, 3'b010, 4'b1111, 32'h0, st);
    store(32'h400, 32'h55555555, 3'b010, 32'h55555555, 4'b1111, st);
    wait_empty("err_sb_empty");
    err_mode = 0;
    load(32'h400, 3'b010, 4'b1111, 32'h0, st);

`ifdef DBUS_TIMEOUT_EN
    no_ack = 1;
    rd_q.push_back(32'h0);
    req(1'b1, 1'b0, 32'h100, 32'h0, 3'b010, st);
    chk("tmo_stall", st, 256);
    no_ack = 0;
`endif

    wait_st = 20;
    req(1'b0, 1'b1, 32'h500, 32'h77777777, 3'b010, st);
    #3;
    chk("pre_rst_cyc", {31'b0, wb_cyc_o}, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_cyc", {31'b0, wb_cyc_o}, 0);
    chk("mid_rst_stb", {31'b0, wb_stb_o}, 0);
    chk("mid_rst_empty", {31'b0, sb_empty_o}, 1);
    @(negedge clk);
    reset_n = 1'b1;
    wait_st = 0;
    @(negedge clk);
    load(32'h500, 3'b010, 4'b1111, 32'h0, st);
    chk("post_rst_stall", st, 2);

    repeat (3) @(negedge clk);
    chk("mis_pulses", mis_cnt, 2);
`ifdef DBUS_TIMEOUT_EN
    chk("berr_pulses", berr_cnt, 3);
`else
    chk("berr_pulses", berr_cnt, 2);
`endif
    chk("bus_q_left", bus_q.size(), 0);
    chk("rd_q_left", rd_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog");
  end

endmodule
